// File: rtl/reset_sequencer.sv
// Board reset conditioner: synchronises and debounces the reset button, merges soft
// resets, stretches the downstream reset to a minimum hold and counts reset events.
module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int HOLD_CYCLES     = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_resetn,
  input  logic       soft_reset_req,
  output logic       sys_reset,
  output logic       ready,
  output logic [7:0] reset_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);

  localparam logic [0:0] ST_HOLD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   db_n_q, db_n_d;
  logic                   db_prev_q;
  logic                   press_evt;
  logic [0:0]             state_q, state_d;
  logic [HD_W-1:0]        hold_q, hold_d;
  logic [7:0]             count_q, count_d;

  // Button synchroniser chain; idles released (all ones)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_resetn};
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES stable cycles
  always_comb begin
    db_cnt_d = db_cnt_q;
    db_n_d   = db_n_q;
    if (btn_s == db_n_q) begin
      db_cnt_d = {DB_W{1'b0}};
    end else if (db_cnt_q == DB_LAST) begin
      db_n_d   = ~db_n_q;
      db_cnt_d = {DB_W{1'b0}};
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Press event is derived from registers only, so it is a clean one-cycle pulse
  assign press_evt = db_prev_q & ~db_n_q;

  // HOLD/RUN sequencing and saturating event counter
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    count_d = count_q;
    case (state_q)
      ST_HOLD: begin
        if (!db_n_q || soft_reset_req) begin
          hold_d = {HD_W{1'b0}};
        end else if (hold_q == HD_LAST) begin
          state_d = ST_RUN;
          hold_d  = {HD_W{1'b0}};
        end else begin
          hold_d = hold_q + HD_W'(1);
        end
      end
      ST_RUN: begin
        if (press_evt || soft_reset_req) begin
          state_d = ST_HOLD;
          hold_d  = {HD_W{1'b0}};
          if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end else begin
            count_d = count_q;
          end
        end else begin
          hold_d = {HD_W{1'b0}};
        end
      end
      default: begin
        state_d = ST_HOLD;
        hold_d  = {HD_W{1'b0}};
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q  <= {DB_W{1'b0}};
      db_n_q    <= 1'b1;
      db_prev_q <= 1'b1;
      state_q   <= ST_HOLD;
      hold_q    <= {HD_W{1'b0}};
      count_q   <= 8'd0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      db_n_q    <= db_n_d;
      db_prev_q <= db_n_q;
      state_q   <= state_d;
      hold_q    <= hold_d;
      count_q   <= count_d;
    end
  end

  assign sys_reset   = (state_q == ST_HOLD);
  assign ready       = ~sys_reset;
  assign reset_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed testbench for reset_sequencer with SYNC_STAGES=2, DEBOUNCE_CYCLES=32, HOLD_CYCLES=16.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_resetn = 1'b1;
  logic       soft_reset_req = 1'b0;
  logic       sys_reset;
  logic       ready;
  logic [7:0] reset_count;

  int vec = 0;
  int miscmp = 0;

  reset_sequencer #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(32),
    .HOLD_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_resetn(btn_resetn),
    .soft_reset_req(soft_reset_req),
    .sys_reset(sys_reset),
    .ready(ready),
    .reset_count(reset_count)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    vec++; if (sys_reset !== 1'b1) begin miscmp++; $display("FAIL reset_sys: got %b want 1", sys_reset); end
    vec++; if (ready !== 1'b0) begin miscmp++; $display("FAIL reset_ready: got %b want 0", ready); end
    vec++; if (reset_count !== 8'd0) begin miscmp++; $display("FAIL reset_count: got %0d want 0", reset_count); end
    repeat (5) step();
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      vec++;
      if (sys_reset !== ((k < 16) ? 1'b1 : 1'b0)) begin
        miscmp++; $display("FAIL powerup_edge%0d: got %b want %b", k, sys_reset, (k < 16));
      end
    end
    vec++; if (ready !== 1'b1) begin miscmp++; $display("FAIL powerup_ready: got %b want 1", ready); end
    vec++; if (reset_count !== 8'd0) begin miscmp++; $display("FAIL powerup_count: got %0d want 0", reset_count); end
  endtask

  task automatic test_glitch();
    int bad = 0;
    step();
    btn_resetn = 1'b0;
    repeat (10) step();
    btn_resetn = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (sys_reset !== 1'b0) bad++;
    end
    vec++; if (bad != 0) begin miscmp++; $display("FAIL glitch_sys: %0d cycles high, want 0", bad); end
    vec++; if (reset_count !== 8'd0) begin miscmp++; $display("FAIL glitch_count: got %0d want 0", reset_count); end
  endtask

  task automatic test_held_press();
    int rise = -1;
    int fall = -1;
    int dropped = 0;
    step();
    btn_resetn = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (rise < 0 && sys_reset === 1'b1) rise = k;
      else if (rise > 0 && sys_reset !== 1'b1) dropped++;
    end
    vec++; if (rise != 35) begin miscmp++; $display("FAIL press_rise: got edge %0d want 35", rise); end
    vec++; if (dropped != 0) begin miscmp++; $display("FAIL press_held: dropped %0d cycles, want 0", dropped); end
    btn_resetn = 1'b1;
    for (int j = 1; j <= 80; j++) begin
      step();
      if (fall < 0 && sys_reset === 1'b0) fall = j;
    end
    vec++; if (fall != 50) begin miscmp++; $display("FAIL release_fall: got edge %0d want 50", fall); end
    vec++; if (reset_count !== 8'd1) begin miscmp++; $display("FAIL press_count: got %0d want 1", reset_count); end
  endtask

  task automatic test_soft_reset();
    step();
    soft_reset_req = 1'b1;
    step();
    soft_reset_req = 1'b0;
    vec++; if (sys_reset !== 1'b1) begin miscmp++; $display("FAIL soft_rise: got %b want 1", sys_reset); end
    vec++; if (reset_count !== 8'd2) begin miscmp++; $display("FAIL soft_count: got %0d want 2", reset_count); end
    for (int k = 2; k <= 17; k++) begin
      step();
      if (k == 16) begin
        vec++; if (sys_reset !== 1'b1) begin miscmp++; $display("FAIL soft_hold16: got %b want 1", sys_reset); end
      end else if (k == 17) begin
        vec++; if (sys_reset !== 1'b0) begin miscmp++; $display("FAIL soft_fall17: got %b want 0", sys_reset); end
      end
    end
  endtask

  task automatic test_coincident();
    step();
    btn_resetn = 1'b0;
    for (int k = 1; k <= 34; k++) step();
    vec++; if (sys_reset !== 1'b0) begin miscmp++; $display("FAIL coin_pre: got %b want 0", sys_reset); end
    soft_reset_req = 1'b1;
    step();
    soft_reset_req = 1'b0;
    btn_resetn = 1'b1;
    vec++; if (sys_reset !== 1'b1) begin miscmp++; $display("FAIL coin_rise: got %b want 1", sys_reset); end
    vec++; if (reset_count !== 8'd3) begin miscmp++; $display("FAIL coin_count: got %0d want 3", reset_count); end
    for (int j = 1; j <= 50; j++) begin
      step();
      if (j == 49) begin
        vec++; if (sys_reset !== 1'b1) begin miscmp++; $display("FAIL coin_hold49: got %b want 1", sys_reset); end
      end else if (j == 50) begin
        vec++; if (sys_reset !== 1'b0) begin miscmp++; $display("FAIL coin_fall50: got %b want 0", sys_reset); end
      end
    end
    vec++; if (reset_count !== 8'd3) begin miscmp++; $display("FAIL coin_count_end: got %0d want 3", reset_count); end
  endtask

  task automatic test_async_reset();
    step();
    #2 reset = 1'b1;
    #1;
    vec++; if (sys_reset !== 1'b1) begin miscmp++; $display("FAIL async_sys: got %b want 1", sys_reset); end
    vec++; if (ready !== 1'b0) begin miscmp++; $display("FAIL async_ready: got %b want 0", ready); end
    vec++; if (reset_count !== 8'd0) begin miscmp++; $display("FAIL async_count: got %0d want 0", reset_count); end
    step();
    step();
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 15) begin
        vec++; if (sys_reset !== 1'b1) begin miscmp++; $display("FAIL async_hold15: got %b want 1", sys_reset); end
      end else if (k == 16) begin
        vec++; if (sys_reset !== 1'b0) begin miscmp++; $display("FAIL async_fall16: got %b want 0", sys_reset); end
      end
    end
  endtask

  task automatic test_hold_restart();
    step();
    soft_reset_req = 1'b1;
    step();
    soft_reset_req = 1'b0;
    vec++; if (reset_count !== 8'd1) begin miscmp++; $display("FAIL restart_count1: got %0d want 1", reset_count); end
    repeat (7) step();
    soft_reset_req = 1'b1;
    step();
    soft_reset_req = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 15) begin
        vec++; if (sys_reset !== 1'b1) begin miscmp++; $display("FAIL restart_hold15: got %b want 1", sys_reset); end
      end else if (k == 16) begin
        vec++; if (sys_reset !== 1'b0) begin miscmp++; $display("FAIL restart_fall16: got %b want 0", sys_reset); end
      end
    end
    vec++; if (reset_count !== 8'd1) begin miscmp++; $display("FAIL restart_count: got %0d want 1", reset_count); end
  endtask

  task automatic test_saturation();
    int exp_cnt = 1;
    for (int p = 0; p < 300; p++) begin
      step();
      soft_reset_req = 1'b1;
      step();
      soft_reset_req = 1'b0;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      vec++;
      if (reset_count !== exp_cnt[7:0]) begin
        miscmp++; $display("FAIL sat_count p%0d: got %0d want %0d", p, reset_count, exp_cnt);
      end
      repeat (16) step();
      vec++;
      if (sys_reset !== 1'b0) begin
        miscmp++; $display("FAIL sat_run p%0d: got %b want 0", p, sys_reset);
      end
    end
    vec++; if (reset_count !== 8'd255) begin miscmp++; $display("FAIL sat_final: got %0d want 255", reset_count); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_held_press();
    test_soft_reset();
    test_coincident();
    test_async_reset();
    test_hold_restart();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
